// File: rtl/shift_seq_if.sv
// Request/result handshake bundle for shift_seq.
//   master : requester (execute-stage control); drives the request and out_ready
//   slave  : shift_seq itself; drives in_ready, out_valid, out_data, busy
interface shift_seq_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic [3:0]       in_amt;
   logic [1:0]       in_op;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic             busy;

   modport master (
      output in_valid, in_data, in_amt, in_op, out_ready,
      input  in_ready, out_valid, out_data, busy
   );

   modport slave (
      input  in_valid, in_data, in_amt, in_op, out_ready,
      output in_ready, out_valid, out_data, busy
   );
endinterface

// File: rtl/shift_seq.sv
// Multi-cycle 16-bit rotate/shift sequencer.
// A request (operand, 4-bit amount, op) is captured in IDLE, then one
// power-of-two stage (8, 4, 2, 1) is applied per clock to the data register.
// Every stage state is visited regardless of amount, so latency is fixed.
//   clk, rst_n : system clock, async active-low reset
//   bus        : shift_seq_if slave port
//                in_valid/in_ready/in_data/in_amt/in_op  request
//                out_valid/out_ready/out_data            result
//                busy                                    state != IDLE
// op: 00 rotl, 01 shl (zero fill), 10 rotr, 11 shr (zero fill)
//
// state | meaning
// IDLE  | ready for a request
// S8    | apply stage 8 if amt[3]
// S4    | apply stage 4 if amt[2]
// S2    | apply stage 2 if amt[1]
// S1    | apply stage 1 if amt[0]
// DONE  | result valid, wait for out_ready
module shift_seq #(
   parameter int WIDTH = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   shift_seq_if.slave  bus
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      S8   = 3'd1,
      S4   = 3'd2,
      S2   = 3'd3,
      S1   = 3'd4,
      DONE = 3'd5
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic [3:0]       amt_q, amt_d;
   logic [1:0]       op_q, op_d;
   logic             in_ready_q, in_ready_d;
   logic             out_valid_q, out_valid_d;
   logic             busy_q, busy_d;

   logic [4:0]       stage_k;
   logic             stage_en;
   logic [WIDTH-1:0] stage_out;

   // Single stage of the rotate/shift datapath. Rotates use the doubled
   // operand so a plain right shift extracts the rotated window.
   function automatic logic [WIDTH-1:0] shift_stage(
      input logic [WIDTH-1:0] d,
      input logic [1:0]       op,
      input logic [4:0]       k
   );
      logic [2*WIDTH-1:0] dd;
      logic [2*WIDTH-1:0] sh;
      logic [WIDTH-1:0]   r;
      dd = {d, d};
      sh = '0;
      r  = d;
      case (op)
         2'b00: begin
            sh = dd >> (5'd16 - k);
            r  = sh[WIDTH-1:0];
         end
         2'b01: r = d << k;
         2'b10: begin
            sh = dd >> k;
            r  = sh[WIDTH-1:0];
         end
         default: r = d >> k;
      endcase
      return r;
   endfunction

   assign stage_out = shift_stage(data_q, op_q, stage_k);

   always_comb begin
      state_d  = state_q;
      data_d   = data_q;
      amt_d    = amt_q;
      op_d     = op_q;
      stage_k  = 5'd0;
      stage_en = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               data_d  = bus.in_data;
               amt_d   = bus.in_amt;
               op_d    = bus.in_op;
               state_d = S8;
            end
         end
         S8: begin
            stage_k  = 5'd8;
            stage_en = amt_q[3];
            state_d  = S4;
         end
         S4: begin
            stage_k  = 5'd4;
            stage_en = amt_q[2];
            state_d  = S2;
         end
         S2: begin
            stage_k  = 5'd2;
            stage_en = amt_q[1];
            state_d  = S1;
         end
         S1: begin
            stage_k  = 5'd1;
            stage_en = amt_q[0];
            state_d  = DONE;
         end
         DONE: begin
            if (bus.out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      if (stage_en) begin
         data_d = stage_out;
      end

      // Outputs are registered from the next state so they line up with state_q.
      in_ready_d  = (state_d == IDLE);
      out_valid_d = (state_d == DONE);
      busy_d      = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         data_q      <= '0;
         amt_q       <= '0;
         op_q        <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         data_q      <= data_d;
         amt_q       <= amt_d;
         op_q        <= op_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.busy      = busy_q;
   assign bus.out_data  = data_q;

endmodule

// File: tb/tb_shift_seq.sv
// Directed bench for shift_seq: expected values are hand-computed constants.
module tb_shift_seq;

   localparam logic [1:0] ROL = 2'b00;
   localparam logic [1:0] SHL = 2'b01;
   localparam logic [1:0] ROR = 2'b10;
   localparam logic [1:0] SHR = 2'b11;

   logic clk;
   logic rst_n;
   int   n_chk;
   int   n_pass;

   shift_seq_if #(.WIDTH(16)) bus ();

   shift_seq #(.WIDTH(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   // Called 1ns after the accepting edge; waits for out_valid (bounded),
   // checks latency and result, and leaves the DUT in DONE.
   task automatic wait_result(input string tag, input logic [15:0] exp);
      int cyc;
      cyc = 0;
      chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
      while (!bus.out_valid && cyc < 20) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      chk({tag, "_lat"}, 32'(cyc), 32'd4);
      chk({tag, "_data"}, 32'(bus.out_data), 32'(exp));
   endtask

   task automatic start_and_wait(input string tag, input logic [15:0] d, input logic [3:0] a,
                                 input logic [1:0] op, input logic [15:0] exp);
      @(negedge clk);
      chk({tag, "_rdy"}, 32'(bus.in_ready), 32'd1);
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      bus.in_amt   = a;
      bus.in_op    = op;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      wait_result(tag, exp);
   endtask

   task automatic consume(input string tag);
      @(negedge clk);
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      chk({tag, "_ov_clr"}, 32'(bus.out_valid), 32'd0);
      chk({tag, "_idle"}, 32'(bus.busy), 32'd0);
      chk({tag, "_rdy_back"}, 32'(bus.in_ready), 32'd1);
   endtask

   task automatic do_op(input string tag, input logic [15:0] d, input logic [3:0] a,
                        input logic [1:0] op, input logic [15:0] exp);
      start_and_wait(tag, d, a, op, exp);
      consume(tag);
   endtask

   initial begin
      logic [3:0]  amts [3];
      logic [15:0] exps [3];
      int          acc_cyc [3];
      int          nacc;
      int          nres;

      n_chk = 0;
      n_pass = 0;
      rst_n = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.in_amt    = '0;
      bus.in_op     = '0;
      bus.out_ready = 1'b0;

      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_out_data", 32'(bus.out_data), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      do_op("rol8", 16'h1234, 4'd8, ROL, 16'h3412);
      do_op("shr15", 16'h8001, 4'd15, SHR, 16'h0001);
      do_op("shl1", 16'h8001, 4'd1, SHL, 16'h0002);
      do_op("shl15", 16'hFFFF, 4'd15, SHL, 16'h8000);
      do_op("ror4", 16'h000F, 4'd4, ROR, 16'hF000);
      do_op("ror15", 16'h0001, 4'd15, ROR, 16'h0002);
      do_op("rol0", 16'hBEEF, 4'd0, ROL, 16'hBEEF);
      do_op("rol5", 16'h8421, 4'd5, ROL, 16'h8430);

      // Backpressure with a new request waiting at the input.
      start_and_wait("bp", 16'h8001, 4'd1, SHL, 16'h0002);
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = 16'h00FF;
      bus.in_amt   = 4'd4;
      bus.in_op    = ROL;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         chk("bp_hold_valid", 32'(bus.out_valid), 32'd1);
         chk("bp_hold_data", 32'(bus.out_data), 32'h0002);
         chk("bp_hold_rdy", 32'(bus.in_ready), 32'd0);
      end
      @(negedge clk);
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      chk("bp_cons_valid", 32'(bus.out_valid), 32'd0);
      chk("bp_cons_rdy", 32'(bus.in_ready), 32'd1);
      chk("bp_cons_data", 32'(bus.out_data), 32'h0002);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      wait_result("bp_pend", 16'h0FF0);
      consume("bp_pend");

      // Reset while in S4.
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = 16'h1234;
      bus.in_amt   = 4'd12;
      bus.in_op    = ROL;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mrst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("mrst_busy", 32'(bus.busy), 32'd0);
      chk("mrst_in_ready", 32'(bus.in_ready), 32'd1);
      chk("mrst_out_data", 32'(bus.out_data), 32'h0);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         chk("mrst_no_valid", 32'(bus.out_valid), 32'd0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      do_op("post_rst", 16'h00F0, 4'd4, ROL, 16'h0F00);

      // Back-to-back with in_valid and out_ready held high.
      amts[0] = 4'd1;
      amts[1] = 4'd2;
      amts[2] = 4'd3;
      exps[0] = 16'h0003;
      exps[1] = 16'h0006;
      exps[2] = 16'h000C;
      nacc = 0;
      nres = 0;
      for (int k = 0; k < 3; k++) acc_cyc[k] = 0;
      bus.in_data   = 16'h8001;
      bus.in_op     = ROL;
      bus.out_ready = 1'b1;
      for (int cyc = 0; cyc < 30; cyc++) begin
         @(negedge clk);
         if (bus.out_valid) begin
            if (nres < 3) begin
               chk("b2b_data", 32'(bus.out_data), 32'(exps[nres]));
            end
            nres++;
         end
         if (bus.in_ready && nacc < 3) begin
            bus.in_valid = 1'b1;
            bus.in_amt   = amts[nacc];
            acc_cyc[nacc] = cyc;
            nacc++;
         end else if (nacc == 3) begin
            bus.in_valid = 1'b0;
         end
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      chk("b2b_accepts", 32'(nacc), 32'd3);
      chk("b2b_results", 32'(nres), 32'd3);
      chk("b2b_gap01", 32'(acc_cyc[1] - acc_cyc[0]), 32'd6);
      chk("b2b_gap12", 32'(acc_cyc[2] - acc_cyc[1]), 32'd6);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/shift_seq.md
# shift_seq

Multi-cycle 16-bit rotate/shift sequencer for the execute stage. It accepts an operand, a 4-bit amount and an operation over a valid/ready handshake. It then applies the power-of-two shift stages (8, 4, 2, 1) one per clock to an internal register, so a single stage datapath is reused instead of a four-level barrel. The result is presented over a valid/ready output handshake; the execute-stage control logic is the only requester.

## Interface
- WIDTH, 16, data width; only 16 is supported (four stages, amounts 0–15).

- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request; equals (state == IDLE).
- in_data  in  16  operand.
- in_amt  in  4  shift/rotate amount.
- in_op  in  2  operation: 00 = rotate left, 01 = shift left logical, 10 = rotate right, 11 = shift right logical.
- out_valid  out  1  result valid; equals (state == DONE).
- out_ready  in  1  consumer accepts the result.
- out_data  out  16  result; driven from the data register.
- busy  out  1  state != IDLE.

## Operation
- Registers:
  - data_r[15:0], amt_r[3:0], op_r[1:0].
  - FSM state: IDLE, S8, S4, S2, S1, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid: capture in_data, in_amt and in_op, then go to S8.
  - Otherwise stay in IDLE.
- Stage states S8 → S4 → S2 → S1 → DONE, one per clock and unconditional:
  - Stage k (k = 8, 4, 2, 1) checks amt_r bit log2(k).
  - If the bit is 1, data_r is updated per op_r:
    - rotate left by k;
    - shift left by k, zero fill;
    - rotate right by k;
    - shift right by k, zero fill.
  - If the bit is 0, data_r holds.
  - Stages are never skipped, so latency does not depend on the amount.
- DONE:
  - out_valid = 1, out_data = data_r.
  - On out_ready, go to IDLE; otherwise hold, with data_r and out_data stable.
- in_valid outside IDLE is ignored; no request is queued.
- Amount 0 returns in_data unchanged. Amount 15 is the full 8 + 4 + 2 + 1 sequence.
- Arithmetic is purely bitwise within 16 bits. No carry or sign output; bits shifted out are discarded.
- Reset (rst_n low, at any time, including mid-operation):
  - state = IDLE; data_r, amt_r, op_r = 0.
  - out_valid = 0, busy = 0, in_ready = 1, out_data = 0x0000.
  - An operation in progress is aborted and produces no result.
- After rst_n deasserts, the first rising edge may accept a request.

## Timing
- Acceptance occurs at edge T when in_valid & in_ready.
- Stage updates happen at edges T+1 (S8), T+2 (S4), T+3 (S2) and T+4 (S1).
- out_valid goes high after edge T+4, i.e. 4 cycles after acceptance.
- The result is consumed at the first edge ≥ T+5 where out_ready = 1. in_ready rises in the following cycle.
- Maximum throughput with out_ready tied high: one operation every 6 cycles (accept at T, next accept at T+6).
- All outputs are decoded from registered state and data only; there is no combinational path from in_* or out_ready to any output.

## Test plan
- Rotate left, in_data = 0x1234, amt = 8:
  - out_data = 0x3412.
  - out_valid first high exactly 4 cycles after accept.
  - busy high from T+1 until the consuming edge.
- Logical shifts:
  - Shift right logical 0x8001 by 15 → 0x0001.
  - Shift left logical 0x8001 by 1 → 0x0002.
  - Shift left logical 0xFFFF by 15 → 0x8000.
- Rotate right and zero amount:
  - Rotate right 0x000F by 4 → 0xF000.
  - Rotate right 0x0001 by 15 → 0x0002.
  - Rotate left 0xBEEF by 0 → 0xBEEF.
- Backpressure:
  - Hold out_ready low for 3 cycles in DONE while in_valid = 1 with new data.
  - out_valid stays 1, out_data stays stable, in_ready stays 0, and the new request is not captured.
  - After out_ready, the block returns to IDLE and then accepts the pending request.
- Reset mid-operation:
  - Assert rst_n low during S4 of rotate left 0x1234 by 12.
  - All outputs take their reset values immediately, and no out_valid appears.
  - After release, rotate left 0x00F0 by 4 → 0x0F00 with correct latency.
- Back-to-back:
  - in_valid held high, out_ready tied high, amounts 1, 2, 3.
  - Accepts occur every 6 cycles, with three correct results in order and no dropped or duplicated out_valid pulses.
